// File: rtl/dcache_nway.sv
// dcache_nway
// N-way set-associative, write-back, write-allocate data cache for the
// memory stage. The CPU side is a word/byte load/store port. The memory side
// is a line-wide request/ready handshake. While a miss is being serviced,
// stall freezes the pipeline.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   MemRead/MemWrite  load/store request from the M stage (both high = store)
//   AddrMode          1 = byte access, 0 = word access
//   data_address      byte address of the access
//   write_data        store data (byte stores use [7:0])
//   read_data         load data, combinational on a hit (bytes zero-extended)
//   stall             miss in progress; the CPU holds its request stable
//   mem_req           memory request valid
//   WriteEnable       1 = line writeback, 0 = line fetch
//   memory_address    line-aligned memory address
//   mem_writedata     victim line for writeback (word0 in the LSBs)
//   mem_readdata      fetched line
//   mem_ready         one-cycle completion pulse from memory
//   hit_count         saturating hit counter
//   miss_count        saturating miss counter
module dcache_nway #(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64,
  parameter int WAYS       = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             MemRead,
  input  logic                             MemWrite,
  input  logic                             AddrMode,
  input  logic [31:0]                      data_address,
  input  logic [31:0]                      write_data,
  output logic [31:0]                      read_data,
  output logic                             stall,
  output logic                             mem_req,
  output logic                             WriteEnable,
  output logic [31:0]                      memory_address,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] mem_writedata,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] mem_readdata,
  input  logic                             mem_ready,
  output logic [31:0]                      hit_count,
  output logic [31:0]                      miss_count
);

  localparam int LINE_W = LINE_WORDS * DATA_WIDTH;
  localparam int OFF_W  = $clog2(LINE_WORDS * 4);
  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  // Cache storage and per-set ages (0 = most recently used)
  logic [WAYS-1:0]   validQ [SETS];
  logic [WAYS-1:0]   dirtyQ [SETS];
  logic [TAG_W-1:0]  tagQ   [SETS][WAYS];
  logic [LINE_W-1:0] dataQ  [SETS][WAYS];
  logic [WAY_W-1:0]  ageQ   [SETS][WAYS];

  // Miss-handling registers
  state_t            stateQ, stateD;
  logic [WAY_W-1:0]  victimQ, victimD;
  logic [31:0]       wbAddrQ, wbAddrD;
  logic [31:0]       fillAddrQ, fillAddrD;
  logic [LINE_W-1:0] wbDataQ, wbDataD;
  logic              retryQ, retryD;
  logic [31:0]       hitCountQ, missCountQ;

  // Request decode
  logic              req;
  logic [IDX_W-1:0]  reqIdx;
  logic [TAG_W-1:0]  reqTag;
  logic [WSEL_W-1:0] wordSel;
  logic [1:0]        byteSel;
  logic [IDX_W-1:0]  fillIdx;

  assign req     = MemRead | MemWrite;
  assign reqIdx  = data_address[OFF_W +: IDX_W];
  assign reqTag  = data_address[31 -: TAG_W];
  assign wordSel = data_address[OFF_W-1:2];
  assign byteSel = data_address[1:0];
  assign fillIdx = fillAddrQ[OFF_W +: IDX_W];

  // Tag lookup across the indexed set
  logic             hit;
  logic [WAY_W-1:0] hitWay;
  always_comb begin
    hit    = 1'b0;
    hitWay = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (validQ[reqIdx][w] && (tagQ[reqIdx][w] == reqTag)) begin
        hit    = 1'b1;
        hitWay = WAY_W'(w);
      end
    end
  end

  // Victim choice: the oldest way by default, overridden by the lowest-index
  // invalid way (the descending loop leaves the lowest one assigned last)
  logic [WAY_W-1:0] victimWay;
  always_comb begin
    victimWay = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (ageQ[reqIdx][w] == WAY_W'(WAYS - 1)) victimWay = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!validQ[reqIdx][w]) victimWay = WAY_W'(w);
    end
  end

  logic              idleHit, idleMiss;
  logic [LINE_W-1:0] hitLine;
  logic [31:0]       hitWord;
  logic [7:0]        hitByte;
  logic [WAY_W-1:0]  hitAge;
  logic              install;

  assign idleHit  = (stateQ == IDLE) && req && hit;
  assign idleMiss = (stateQ == IDLE) && req && !hit;
  assign hitLine  = dataQ[reqIdx][hitWay];
  assign hitWord  = hitLine[{wordSel, 5'b00000} +: 32];
  assign hitByte  = hitWord[{byteSel, 3'b000} +: 8];
  assign hitAge   = ageQ[reqIdx][hitWay];
  assign install  = (stateQ == ALLOCATE) && mem_ready;

  assign read_data  = idleHit ? (AddrMode ? {24'b0, hitByte} : hitWord) : 32'b0;
  assign stall      = (stateQ != IDLE) || idleMiss;
  assign hit_count  = hitCountQ;
  assign miss_count = missCountQ;

  // Next-state and memory-side outputs. Memory outputs come from registered
  // state only, so a reset drops mem_req without waiting for a clock edge.
  always_comb begin
    stateD         = stateQ;
    victimD        = victimQ;
    wbAddrD        = wbAddrQ;
    fillAddrD      = fillAddrQ;
    wbDataD        = wbDataQ;
    retryD         = 1'b0;
    mem_req        = 1'b0;
    WriteEnable    = 1'b0;
    memory_address = 32'b0;
    mem_writedata  = '0;
    case (stateQ)
      IDLE: begin
        if (idleMiss) begin
          victimD   = victimWay;
          wbAddrD   = {tagQ[reqIdx][victimWay], reqIdx, {OFF_W{1'b0}}};
          fillAddrD = {data_address[31:OFF_W], {OFF_W{1'b0}}};
          wbDataD   = dataQ[reqIdx][victimWay];
          stateD    = (validQ[reqIdx][victimWay] && dirtyQ[reqIdx][victimWay])
                      ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_req        = 1'b1;
        WriteEnable    = 1'b1;
        memory_address = wbAddrQ;
        mem_writedata  = wbDataQ;
        if (mem_ready) stateD = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req        = 1'b1;
        memory_address = fillAddrQ;
        if (mem_ready) begin
          stateD = IDLE;
          retryD = 1'b1;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // Control state, line status, ages and counters. retryQ marks the first
  // IDLE cycle after a fill, whose hit belongs to the miss already counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ     <= IDLE;
      victimQ    <= '0;
      wbAddrQ    <= '0;
      fillAddrQ  <= '0;
      wbDataQ    <= '0;
      retryQ     <= 1'b0;
      hitCountQ  <= '0;
      missCountQ <= '0;
      for (int s = 0; s < SETS; s++) begin
        validQ[s] <= '0;
        dirtyQ[s] <= '0;
        for (int w = 0; w < WAYS; w++) ageQ[s][w] <= WAY_W'(w);
      end
    end else begin
      stateQ    <= stateD;
      victimQ   <= victimD;
      wbAddrQ   <= wbAddrD;
      fillAddrQ <= fillAddrD;
      wbDataQ   <= wbDataD;
      retryQ    <= retryD;
      if (idleMiss && (missCountQ != 32'hFFFF_FFFF)) missCountQ <= missCountQ + 32'd1;
      if (idleHit && !retryQ && (hitCountQ != 32'hFFFF_FFFF)) hitCountQ <= hitCountQ + 32'd1;
      if (idleHit) begin
        if (MemWrite) dirtyQ[reqIdx][hitWay] <= 1'b1;
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == hitWay) ageQ[reqIdx][w] <= '0;
          else if (ageQ[reqIdx][w] < hitAge) ageQ[reqIdx][w] <= ageQ[reqIdx][w] + 1'b1;
        end
      end
      if (install) begin
        validQ[fillIdx][victimQ] <= 1'b1;
        dirtyQ[fillIdx][victimQ] <= 1'b0;
      end
    end
  end

  // Tags and line data need no reset; valid bits gate every use of them
  always_ff @(posedge clk) begin
    if (idleHit && MemWrite) begin
      if (AddrMode) dataQ[reqIdx][hitWay][{wordSel, byteSel, 3'b000} +: 8] <= write_data[7:0];
      else          dataQ[reqIdx][hitWay][{wordSel, 5'b00000} +: 32]      <= write_data;
    end
    if (install) begin
      dataQ[fillIdx][victimQ] <= mem_readdata;
      tagQ[fillIdx][victimQ]  <= fillAddrQ[31 -: TAG_W];
    end
  end

endmodule

// File: tb/tb_dcache_nway.sv
// tb_dcache_nway
// Self-checking bench for dcache_nway (default geometry: 4-word lines,
// 64 sets, 2 ways). A behavioural cache model with timestamp LRU and a
// line-addressed backing memory supplies every expected value.
module tb_dcache_nway;

  localparam int LW        = 4;
  localparam int SETS      = 64;
  localparam int WAYS      = 2;
  localparam int LINE_BITS = LW * 32;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 MemRead = 1'b0, MemWrite = 1'b0, AddrMode = 1'b0;
  logic [31:0]          data_address = '0, write_data = '0;
  logic [31:0]          read_data;
  logic                 stall, mem_req, WriteEnable;
  logic [31:0]          memory_address;
  logic [LINE_BITS-1:0] mem_writedata;
  logic [LINE_BITS-1:0] mem_readdata = '0;
  logic                 mem_ready = 1'b0;
  logic [31:0]          hit_count, miss_count;

  int errors = 0;
  int checks = 0;

  dcache_nway #(.DATA_WIDTH(32), .LINE_WORDS(LW), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .AddrMode(AddrMode),
    .data_address(data_address), .write_data(write_data), .read_data(read_data),
    .stall(stall), .mem_req(mem_req), .WriteEnable(WriteEnable),
    .memory_address(memory_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [LINE_BITS-1:0] mem [logic [31:0]];
  bit                   mValid [SETS][WAYS];
  bit                   mDirty [SETS][WAYS];
  logic [31:0]          mTag   [SETS][WAYS];
  logic [LINE_BITS-1:0] mLine  [SETS][WAYS];
  longint               mStamp [SETS][WAYS];
  longint               stampCtr;
  int                   expHits, expMisses;

  // Backing memory: lines never written back hold an address-derived pattern
  function automatic logic [LINE_BITS-1:0] memLine(input logic [31:0] a);
    logic [LINE_BITS-1:0] l;
    if (mem.exists(a)) return mem[a];
    for (int i = 0; i < LW; i++) l[32*i +: 32] = a * 32'h9E37_79B1 + i * 32'h1234_5679 + 32'h0F0F;
    return l;
  endfunction

  task automatic modelReset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        mValid[s][w] = 0;
        mDirty[s][w] = 0;
        mStamp[s][w] = -w;
      end
    stampCtr  = 0;
    expHits   = 0;
    expMisses = 0;
  endtask

  task automatic modelAccess(input bit wr, input bit bm, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic [31:0] expRd,
                             output bit expMiss, output bit expWb,
                             output logic [31:0] expWbAddr, output logic [LINE_BITS-1:0] expWbData);
    int          set  = int'((addr >> 4) % SETS);
    logic [31:0] tag  = addr >> 10;
    int          word = int'((addr >> 2) % LW);
    int          bsel = int'(addr % 4);
    int          way  = -1;
    logic [31:0] w32;
    expWb = 0;
    expWbAddr = '0;
    expWbData = '0;
    for (int w = 0; w < WAYS; w++) if (mValid[set][w] && mTag[set][w] == tag) way = w;
    expMiss = (way < 0);
    if (expMiss) begin
      expMisses++;
      for (int w = 0; w < WAYS; w++) if (!mValid[set][w] && way < 0) way = w;
      if (way < 0) begin
        way = 0;
        for (int w = 1; w < WAYS; w++) if (mStamp[set][w] < mStamp[set][way]) way = w;
      end
      if (mValid[set][way] && mDirty[set][way]) begin
        expWb     = 1;
        expWbAddr = (mTag[set][way] << 10) | (set << 4);
        expWbData = mLine[set][way];
        mem[expWbAddr] = expWbData;
      end
      mLine[set][way]  = memLine(addr & ~32'hF);
      mTag[set][way]   = tag;
      mValid[set][way] = 1;
      mDirty[set][way] = 0;
    end else begin
      expHits++;
    end
    stampCtr++;
    mStamp[set][way] = stampCtr;
    if (wr) begin
      if (bm) mLine[set][way][32*word + 8*bsel +: 8] = wdata[7:0];
      else    mLine[set][way][32*word +: 32]         = wdata;
      mDirty[set][way] = 1;
    end
    w32   = mLine[set][way][32*word +: 32];
    expRd = bm ? {24'b0, w32[8*bsel +: 8]} : w32;
  endtask

  // Drives one CPU access, acts as memory (ready after 'delay' waiting
  // cycles per request) and reports what it observed; callers compare
  task automatic applyStimulus(input bit rd, input bit wr, input bit bm,
                               input logic [31:0] addr, input logic [31:0] wdata, input int delay,
                               output logic [31:0] rdata, output bit missed, output bit sawWb,
                               output logic [31:0] wbAddr, output logic [LINE_BITS-1:0] wbData,
                               output logic [31:0] fillAddr, output int stallCycles,
                               output bit unstable, output bit timedOut);
    int          waitCnt = 0;
    bit          inPhase = 0;
    logic [31:0] phaseAddr = '0;
    logic        phaseWe = 1'b0;
    sawWb = 0; wbAddr = '0; wbData = '0; fillAddr = 32'hFFFF_FFFF;
    unstable = 0; timedOut = 0; stallCycles = 0;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; AddrMode = bm; data_address = addr; write_data = wdata;
    #1;
    missed = stall;
    while (stall && !timedOut) begin
      if (mem_req) begin
        if (inPhase && (memory_address !== phaseAddr || WriteEnable !== phaseWe)) unstable = 1;
        if (!inPhase) begin
          inPhase = 1; phaseAddr = memory_address; phaseWe = WriteEnable;
        end
        if (WriteEnable) begin
          sawWb = 1; wbAddr = memory_address; wbData = mem_writedata;
        end else begin
          fillAddr = memory_address;
        end
        if (waitCnt >= delay) begin
          mem_ready    = 1'b1;
          mem_readdata = WriteEnable ? {LW{$urandom}} : memLine(memory_address);
          inPhase = 0;
          waitCnt = 0;
        end else begin
          waitCnt++;
        end
      end else if (inPhase) begin
        unstable = 1;
      end
      @(posedge clk); #1; mem_ready = 1'b0;
      @(negedge clk); #1;
      stallCycles++;
      if (stallCycles > 200) timedOut = 1;
    end
    rdata = read_data;
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  logic [31:0]          rdata, wbAddr, fillAddr, expRd, expWbAddr;
  logic [LINE_BITS-1:0] wbData, expWbData;
  bit                   missed, sawWb, unstable, timedOut, expMiss, expWb;
  int                   cyc;

  task automatic test_reset();
    rst = 1'b1;
    modelReset();
    @(negedge clk); #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
    checks++; if (WriteEnable !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b expected 0", WriteEnable); end
    checks++; if (memory_address !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", memory_address); end
    checks++; if (mem_writedata !== '0) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 0", mem_writedata); end
    checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin errors++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", hit_count, miss_count); end
    checks++; if (stall !== 1'b0 || read_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_idle_outputs: stall %b data %h expected 0/0", stall, read_data); end
    rst = 1'b0;
    @(negedge clk);
    mem_ready = 1'b1;
    @(posedge clk); #1; mem_ready = 1'b0;
    @(negedge clk); #1;
    checks++; if (mem_req !== 1'b0 || stall !== 1'b0 || miss_count !== 32'h0) begin errors++; $display("[TB] FAIL stray_ready: req %b stall %b misses %0d expected 0/0/0", mem_req, stall, miss_count); end
  endtask

  task automatic test_miss_refill();
    mem[32'h100] = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    modelAccess(0, 0, 32'h100, 32'h0, expRd, expMiss, expWb, expWbAddr, expWbData);
    applyStimulus(1, 0, 0, 32'h100, 32'h0, 0, rdata, missed, sawWb, wbAddr, wbData, fillAddr, cyc, unstable, timedOut);
    checks++; if (!missed || timedOut) begin errors++; $display("[TB] FAIL refill_stall: stall %b timeout %b expected 1/0", missed, timedOut); end
    checks++; if (fillAddr !== 32'h100 || sawWb) begin errors++; $display("[TB] FAIL refill_fetch: addr %h wb %b expected 00000100/0", fillAddr, sawWb); end
    checks++; if (rdata !== 32'hAAAAAAAA) begin errors++; $display("[TB] FAIL refill_data: got %h expected aaaaaaaa", rdata); end
    checks++; if (miss_count !== 32'd1 || hit_count !== 32'd0) begin errors++; $display("[TB] FAIL refill_counters: got %0d/%0d expected 1/0", miss_count, hit_count); end
    checks++; if (cyc != 2) begin errors++; $display("[TB] FAIL refill_latency: got %0d expected 2", cyc); end
  endtask

  task automatic test_byte_hit();
    modelAccess(1, 1, 32'h101, 32'h1234565A, expRd, expMiss, expWb, expWbAddr, expWbData);
    applyStimulus(0, 1, 1, 32'h101, 32'h1234565A, 0, rdata, missed, sawWb, wbAddr, wbData, fillAddr, cyc, unstable, timedOut);
    checks++; if (missed) begin errors++; $display("[TB] FAIL byte_store_stall: got 1 expected 0"); end
    modelAccess(0, 1, 32'h101, 32'h0, expRd, expMiss, expWb, expWbAddr, expWbData);
    applyStimulus(1, 0, 1, 32'h101, 32'h0, 0, rdata, missed, sawWb, wbAddr, wbData, fillAddr, cyc, unstable, timedOut);
    checks++; if (missed || rdata !== 32'h0000005A) begin errors++; $display("[TB] FAIL byte_load: stall %b data %h expected 0/0000005a", missed, rdata); end
    modelAccess(0, 0, 32'h100, 32'h0, expRd, expMiss, expWb, expWbAddr, expWbData);
    applyStimulus(1, 0, 0, 32'h100, 32'h0, 0, rdata, missed, sawWb, wbAddr, wbData, fillAddr, cyc, unstable, timedOut);
    checks++; if (missed || rdata !== 32'hAAAA5AAA) begin errors++; $display("[TB] FAIL merged_word: stall %b data %h expected 0/aaaa5aaa", missed, rdata); end
    checks++; if (hit_count !== 32'd3) begin errors++; $display("[TB] FAIL byte_hit_count: got %0d expected 3", hit_count); end
  endtask

  task automatic test_dirty_eviction();
    modelAccess(0, 0, 32'h500, 32'h0, expRd, expMiss, expWb, expWbAddr, expWbData);
    applyStimulus(1, 0, 0, 32'h500, 32'h0, 0, rdata, missed, sawWb, wbAddr, wbData, fillAddr, cyc, unstable, timedOut);
    checks++; if (!missed || sawWb || fillAddr !== 32'h500) begin errors++; $display("[TB] FAIL evict_first_fill: miss %b wb %b addr %h expected 1/0/00000500", missed, sawWb, fillAddr); end
    modelAccess(0, 0, 32'h500, 32'h0, expRd, expMiss, expWb, expWbAddr, expWbData);
    applyStimulus(1, 0, 0, 32'h500, 32'h0, 0, rdata, missed, sawWb, wbAddr, wbData, fillAddr, cyc, unstable, timedOut);
    checks++; if (missed || rdata !== expRd) begin errors++; $display("[TB] FAIL evict_rehit: miss %b data %h expected 0/%h", missed, rdata, expRd); end
    modelAccess(0, 0, 32'h900, 32'h0, expRd, expMiss, expWb, expWbAddr, expWbData);
    applyStimulus(1, 0, 0, 32'h900, 32'h0, 1, rdata, missed, sawWb, wbAddr, wbData, fillAddr, cyc, unstable, timedOut);
    checks++; if (!sawWb || wbAddr !== 32'h100 || wbData[31:0] !== 32'hAAAA5AAA) begin errors++; $display("[TB] FAIL evict_writeback: wb %b addr %h word0 %h expected 1/00000100/aaaa5aaa", sawWb, wbAddr, wbData[31:0]); end
    checks++; if (wbData !== expWbData) begin errors++; $display("[TB] FAIL evict_wb_line: got %h expected %h", wbData, expWbData); end
    checks++; if (fillAddr !== 32'h900 || rdata !== expRd) begin errors++; $display("[TB] FAIL evict_fill: addr %h data %h expected 00000900/%h", fillAddr, rdata, expRd); end
    checks++; if (cyc != 5 || unstable) begin errors++; $display("[TB] FAIL evict_latency: cycles %0d unstable %b expected 5/0", cyc, unstable); end
    checks++; if (miss_count !== 32'd3 || hit_count !== 32'd4) begin errors++; $display("[TB] FAIL evict_counters: got %0d/%0d expected 3/4", miss_count, hit_count); end
  endtask

  task automatic test_slow_memory();
    modelAccess(0, 0, 32'h3040, 32'h0, expRd, expMiss, expWb, expWbAddr, expWbData);
    applyStimulus(1, 0, 0, 32'h3040, 32'h0, 5, rdata, missed, sawWb, wbAddr, wbData, fillAddr, cyc, unstable, timedOut);
    checks++; if (unstable || timedOut) begin errors++; $display("[TB] FAIL slow_stable: unstable %b timeout %b expected 0/0", unstable, timedOut); end
    checks++; if (cyc != 7 || fillAddr !== 32'h3040) begin errors++; $display("[TB] FAIL slow_latency: cycles %0d addr %h expected 7/00003040", cyc, fillAddr); end
    checks++; if (rdata !== expRd) begin errors++; $display("[TB] FAIL slow_data: got %h expected %h", rdata, expRd); end
  endtask

  task automatic test_reset_mid_fill();
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; AddrMode = 1'b0; data_address = 32'h7000;
    @(negedge clk); #1;
    checks++; if (mem_req !== 1'b1 || WriteEnable !== 1'b0 || memory_address !== 32'h7000) begin errors++; $display("[TB] FAIL midfill_alloc: req %b we %b addr %h expected 1/0/00007000", mem_req, WriteEnable, memory_address); end
    #1 rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL midfill_async_drop: got %b expected 0", mem_req); end
    checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("[TB] FAIL midfill_counters: got %0d/%0d expected 0/0", hit_count, miss_count); end
    MemRead = 1'b0;
    @(negedge clk); rst = 1'b0;
    modelReset();
    modelAccess(0, 0, 32'h100, 32'h0, expRd, expMiss, expWb, expWbAddr, expWbData);
    applyStimulus(1, 0, 0, 32'h100, 32'h0, 0, rdata, missed, sawWb, wbAddr, wbData, fillAddr, cyc, unstable, timedOut);
    checks++; if (!missed || rdata !== 32'hAAAA5AAA || miss_count !== 32'd1) begin errors++; $display("[TB] FAIL midfill_refetch: miss %b data %h misses %0d expected 1/aaaa5aaa/1", missed, rdata, miss_count); end
    modelAccess(0, 0, 32'h7000, 32'h0, expRd, expMiss, expWb, expWbAddr, expWbData);
    applyStimulus(1, 0, 0, 32'h7000, 32'h0, 0, rdata, missed, sawWb, wbAddr, wbData, fillAddr, cyc, unstable, timedOut);
    checks++; if (!missed || rdata !== expRd) begin errors++; $display("[TB] FAIL midfill_not_installed: miss %b data %h expected 1/%h", missed, rdata, expRd); end
  endtask

  task automatic test_alignment();
    modelAccess(0, 0, 32'h103, 32'h0, expRd, expMiss, expWb, expWbAddr, expWbData);
    applyStimulus(1, 0, 0, 32'h103, 32'h0, 0, rdata, missed, sawWb, wbAddr, wbData, fillAddr, cyc, unstable, timedOut);
    checks++; if (missed || rdata !== 32'hAAAA5AAA) begin errors++; $display("[TB] FAIL align_word0: stall %b data %h expected 0/aaaa5aaa", missed, rdata); end
    modelAccess(0, 0, 32'h10E, 32'h0, expRd, expMiss, expWb, expWbAddr, expWbData);
    applyStimulus(1, 0, 0, 32'h10E, 32'h0, 0, rdata, missed, sawWb, wbAddr, wbData, fillAddr, cyc, unstable, timedOut);
    checks++; if (missed || rdata !== 32'hDDDDDDDD) begin errors++; $display("[TB] FAIL align_word3: stall %b data %h expected 0/dddddddd", missed, rdata); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int          op    = int'($urandom_range(0, 3));
      bit          rd    = (op != 2);
      bit          wr    = (op >= 2);
      bit          bm    = $urandom_range(0, 1) == 1;
      int          delay = int'($urandom_range(0, 2));
      logic [31:0] addr  = ($urandom_range(0, 5) << 10) | ((16 + $urandom_range(0, 1)) << 4) | $urandom_range(0, 15);
      logic [31:0] wd    = $urandom;
      int          expCyc;
      modelAccess(wr, bm, addr, wd, expRd, expMiss, expWb, expWbAddr, expWbData);
      applyStimulus(rd, wr, bm, addr, wd, delay, rdata, missed, sawWb, wbAddr, wbData, fillAddr, cyc, unstable, timedOut);
      expCyc = expMiss ? (1 + (expWb ? delay + 1 : 0) + delay + 1) : 0;
      checks++; if (missed !== expMiss || sawWb !== expWb || timedOut) begin errors++; $display("[TB] FAIL rand_kind %h: miss %b wb %b to %b expected %b/%b/0", addr, missed, sawWb, timedOut, expMiss, expWb); end
      if (expWb) begin
        checks++; if (wbAddr !== expWbAddr || wbData !== expWbData) begin errors++; $display("[TB] FAIL rand_wb %h: addr %h data %h expected %h/%h", addr, wbAddr, wbData, expWbAddr, expWbData); end
      end
      if (expMiss) begin
        checks++; if (fillAddr !== (addr & ~32'hF) || cyc != expCyc || unstable) begin errors++; $display("[TB] FAIL rand_fill %h: addr %h cycles %0d unstable %b expected %h/%0d/0", addr, fillAddr, cyc, unstable, addr & ~32'hF, expCyc); end
      end
      if (!wr) begin
        checks++; if (rdata !== expRd) begin errors++; $display("[TB] FAIL rand_read %h: got %h expected %h", addr, rdata, expRd); end
      end
      checks++; if (hit_count !== 32'(expHits) || miss_count !== 32'(expMisses)) begin errors++; $display("[TB] FAIL rand_counters: got %0d/%0d expected %0d/%0d", hit_count, miss_count, expHits, expMisses); end
    end
  endtask

  initial begin
    $display("[TB] dcache_nway bench start");
    test_reset();
    test_miss_refill();
    test_byte_hit();
    test_dirty_eviction();
    test_slow_memory();
    test_reset_mid_fill();
    test_alignment();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_nway.md
Name: dcache_nway

Overview:
Parametrised N-way set-associative, write-back, write-allocate data cache. It is the successor to the fixed single-configuration cache in the memory stage. It sits between the M-stage (ALUResultM/WriteDataM) and the line-wide datamem handshake, and drives a stall that freezes F/D/E/M while a miss is serviced. It adds configurable sets, ways and line size, true LRU replacement, dirty-line writeback, and hit/miss performance counters.

Parameters:
DATA_WIDTH, 32, CPU word width (fixed 32 for byte lanes)
LINE_WORDS, 4, words per line (power of 2, >=2); memory-side bus = LINE_WORDS*DATA_WIDTH
SETS, 64, number of sets (power of 2)
WAYS, 2, associativity (power of 2, 1..8)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
MemRead  in  1  load in M stage
MemWrite  in  1  store in M stage
AddrMode  in  1  1=byte (lbu/sb), 0=word
data_address  in  32  byte address
write_data  in  32  store data (byte from [7:0])
read_data  out  32  load data; byte zero-extended
stall  out  1  miss in progress; CPU holds request stable
mem_req  out  1  memory request valid
WriteEnable  out  1  1=line writeback, 0=line fetch
memory_address  out  32  line-aligned address
mem_writedata  out  LINE_WORDS*32  victim line, word0 in LSBs
mem_readdata  in  LINE_WORDS*32  fetched line
mem_ready  in  1  memory completes current request (one-cycle pulse)
hit_count  out  32  hits, saturating
miss_count  out  32  misses, saturating

Behaviour:
- Address split: offset = [log2(LINE_WORDS*4)-1:0]; index = next log2(SETS) bits; tag = remainder. Word accesses ignore address[1:0].
- Per line: valid, dirty, tag, data. Per set: per-way age (log2(WAYS) bits).
- Reset: all valid/dirty=0; ages[w]=w; state IDLE; mem_req=0, WriteEnable=0, memory_address=0, mem_writedata=0, counters=0. With no request pending: stall=0, read_data=0.
- Reset mid-operation: FSM returns to IDLE immediately and mem_req drops asynchronously. Lines being written back or filled are lost; no partial line is installed.
- req = MemRead|MemWrite. Hit = any valid way with matching tag in the indexed set.
- IDLE, hit: read_data is combinational in the same cycle; stall=0. A store writes its byte/word on the clock edge and sets dirty. The accessed way's age becomes 0; ways with age below its old age increment by 1.
- IDLE, miss: stall=1 combinationally in the same cycle.
  - Victim = lowest-index invalid way; otherwise the way with age WAYS-1.
  - Latch the victim way and addresses.
  - Victim valid & dirty -> WRITEBACK; otherwise -> ALLOCATE. miss_count+1.
- WRITEBACK: mem_req=1, WriteEnable=1, memory_address={victim tag,index,0}, mem_writedata=victim line. Outputs held stable until mem_ready, then -> ALLOCATE.
- ALLOCATE: mem_req=1, WriteEnable=0, memory_address=request address with offset zeroed. On mem_ready: install mem_readdata into the victim, set tag, valid=1, dirty=0, then -> IDLE. stall stays 1 through this cycle.
- First IDLE cycle after ALLOCATE: the retried access hits and completes (store merges, LRU update). It is not counted in hit_count. All other IDLE hits increment hit_count.
- mem_ready while mem_req=0 is ignored.
- Miss latency = (writeback handshake cycles) + (fetch handshake cycles) + 1.
- MemRead and MemWrite both high: treated as a store.
- Counters saturate at 0xFFFFFFFF.
- Nothing in the cache is written while stall=1, except the line install.

Test Plan:
- Miss refill: reset, then load word 0x100. Required: stall=1, mem_req=1, WE=0, memory_address=0x100. Drive mem_ready=1 with line {0xDDDDDDDD,0xCCCCCCCC,0xBBBBBBBB,0xAAAAAAAA}. Next cycle: stall=0, read_data=0xAAAAAAAA, miss_count=1, hit_count=0.
- Byte hit: store byte 0x5A to 0x101, then load byte 0x101, then load word 0x100. Required: no stall on any access; reads return 0x0000005A and 0xAAAA5AAA; hit_count=3.
- Dirty eviction: continue from the byte-hit test (0x100, 0x500 and 0x900 all map to set 16). Load 0x500 (miss, way1), load 0x500 again, then load 0x900. Required: victim is the 0x100 line; WRITEBACK with WE=1, memory_address=0x100, mem_writedata[31:0]=0xAAAA5AAA; then ALLOCATE at 0x900; miss_count=3.
- Slow memory: hold mem_ready low for 5 cycles in ALLOCATE. Required: stall=1 and mem_req/memory_address unchanged throughout; completion on the 6th cycle.
- Reset mid-fill: assert rst during ALLOCATE. Required: mem_req=0 immediately, counters=0, and a subsequent load of 0x100 misses again.
- Alignment: load word at 0x103 after the 0x100 line is resident. Required: returns word0 with no stall.
